// File: rtl/dual_core_seq_pkg.sv
// Shared types and default parameters for the dual-core fetch sequencer.
package dual_core_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_TIMEOUT
  } seq_state_e;

  localparam int DEF_CNT_W    = 32;
  localparam int DEF_MAX_SKEW = 2;
  localparam int DEF_TIMEOUT  = 1024;

endpackage

// File: rtl/dual_core_fetch_sequencer_if.sv
// Control and per-core event bundle between the harness and the fetch sequencer.
interface dual_core_fetch_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             start_i;
  logic [CNT_W-1:0] budget_i;
  logic             fetch_1_i;
  logic             fetch_2_i;
  logic             retire_1_i;
  logic             retire_2_i;
  logic             enable_1_o;
  logic             enable_2_o;
  logic             busy_o;
  logic             finished_o;
  logic             timeout_o;
  logic [CNT_W-1:0] fetch_cnt_1_o;
  logic [CNT_W-1:0] fetch_cnt_2_o;

  modport master (
    output start_i, budget_i, fetch_1_i, fetch_2_i, retire_1_i, retire_2_i,
    input  enable_1_o, enable_2_o, busy_o, finished_o, timeout_o,
           fetch_cnt_1_o, fetch_cnt_2_o
  );

  modport slave (
    input  start_i, budget_i, fetch_1_i, fetch_2_i, retire_1_i, retire_2_i,
    output enable_1_o, enable_2_o, busy_o, finished_o, timeout_o,
           fetch_cnt_1_o, fetch_cnt_2_o
  );
endinterface

// File: rtl/seq_watchdog.sv
// Idle-cycle watchdog: counts cycles without activity, flags expiry on the
// last permitted idle cycle so the owner can abort on that same edge.
module seq_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear,
  input  logic cnt_en,
  input  logic evt,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                      cnt_q <= '0;
    else if (clear || (cnt_en && evt)) cnt_q <= '0;
    else if (cnt_en && cnt_q != LAST)  cnt_q <= cnt_q + W'(1);
  end

  assign expired = cnt_en && !evt && (cnt_q == LAST);
endmodule

// File: rtl/dual_core_fetch_sequencer.sv
// Runs two cores over a shared instruction budget with bounded fetch skew,
// waits for both to retire everything, and aborts on an idle watchdog.
module dual_core_fetch_sequencer
  import dual_core_seq_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int MAX_SKEW = DEF_MAX_SKEW,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input logic                        clk_i,
  input logic                        rst_ni,
  dual_core_fetch_sequencer_if.slave bus
);
  localparam logic signed [CNT_W:0] SKEW = (CNT_W + 1)'(MAX_SKEW);

  seq_state_e             state_q, state_d;
  logic [CNT_W-1:0]       budget_q;
  logic [1:0][CNT_W-1:0]  fcnt, fnext, rnext;
  logic [1:0]             fetch, retire, en, f_inc, r_inc;
  logic                   run, active, start_acc, evt;
  logic                   fetch_done, retire_done, wd_exp;

  assign fetch     = {bus.fetch_2_i, bus.fetch_1_i};
  assign retire    = {bus.retire_2_i, bus.retire_1_i};
  assign run       = (state_q == S_RUN);
  assign active    = run || (state_q == S_DRAIN);
  assign start_acc = bus.start_i && !active;

  for (genvar k = 0; k < 2; k++) begin : g_core
    localparam int O = 1 - k;
    logic [CNT_W-1:0]      fcnt_q, rcnt_q;
    logic signed [CNT_W:0] lead;

    // Lead over the other core, widened so a trailing core reads negative.
    assign lead     = {1'b0, fcnt_q} - {1'b0, fcnt[O]};
    assign en[k]    = run && (fcnt_q < budget_q) && (lead < SKEW);
    assign f_inc[k] = en[k] && fetch[k];
    assign r_inc[k] = active && retire[k] && (rcnt_q < budget_q);
    assign fnext[k] = fcnt_q + CNT_W'(f_inc[k]);
    assign rnext[k] = rcnt_q + CNT_W'(r_inc[k]);
    assign fcnt[k]  = fcnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        fcnt_q <= '0;
        rcnt_q <= '0;
      end else if (start_acc) begin
        fcnt_q <= '0;
        rcnt_q <= '0;
      end else begin
        fcnt_q <= fnext[k];
        rcnt_q <= rnext[k];
      end
    end
  end

  assign evt         = |f_inc || |r_inc;
  assign fetch_done  = (fnext[0] == budget_q) && (fnext[1] == budget_q);
  assign retire_done = (rnext[0] == budget_q) && (rnext[1] == budget_q);

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear   (start_acc),
    .cnt_en  (active),
    .evt     (evt),
    .expired (wd_exp)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      budget_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) budget_q <= bus.budget_i;
    end
  end

  // Completion is tested before expiry so a finishing cycle never aborts.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_TIMEOUT:
        if (start_acc) state_d = (bus.budget_i == '0) ? S_DONE : S_RUN;
      S_RUN:
        if (fetch_done)  state_d = S_DRAIN;
        else if (wd_exp) state_d = S_TIMEOUT;
      S_DRAIN:
        if (retire_done) state_d = S_DONE;
        else if (wd_exp) state_d = S_TIMEOUT;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.enable_1_o    = en[0];
  assign bus.enable_2_o    = en[1];
  assign bus.busy_o        = active;
  assign bus.finished_o    = (state_q == S_DONE);
  assign bus.timeout_o     = (state_q == S_TIMEOUT);
  assign bus.fetch_cnt_1_o = fcnt[0];
  assign bus.fetch_cnt_2_o = fcnt[1];
endmodule

// File: tb/tb_dual_core_fetch_sequencer.sv
// Directed scenarios plus random traffic, checked every cycle against a
// phase/count model of the sequencing rules.
module tb_dual_core_fetch_sequencer;
  localparam int CNT_W    = 8;
  localparam int MAX_SKEW = 2;
  localparam int TIMEOUT  = 16;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3, P_TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  dual_core_fetch_sequencer_if #(.CNT_W(CNT_W)) bus();

  dual_core_fetch_sequencer #(
    .CNT_W(CNT_W), .MAX_SKEW(MAX_SKEW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_ph = P_IDLE;
  int mB = 0, mf1 = 0, mf2 = 0, mr1 = 0, mr2 = 0, midle = 0;

  function automatic bit m_en(input int mine, input int other);
    return (m_ph == P_RUN) && (mine < mB) && ((mine - other) < MAX_SKEW);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit c1, c2, q1, q2, e;
    if (m_ph != P_RUN && m_ph != P_DRAIN) begin
      if (bus.start_i) begin
        mB = int'(bus.budget_i);
        mf1 = 0; mf2 = 0; mr1 = 0; mr2 = 0; midle = 0;
        m_ph = (mB == 0) ? P_DONE : P_RUN;
      end
    end else begin
      c1 = m_en(mf1, mf2) && bus.fetch_1_i;
      c2 = m_en(mf2, mf1) && bus.fetch_2_i;
      q1 = bus.retire_1_i && (mr1 < mB);
      q2 = bus.retire_2_i && (mr2 < mB);
      e  = c1 || c2 || q1 || q2;
      mf1 += int'(c1); mf2 += int'(c2); mr1 += int'(q1); mr2 += int'(q2);
      if (m_ph == P_RUN && mf1 == mB && mf2 == mB) m_ph = P_DRAIN;
      else if (m_ph == P_DRAIN && mr1 == mB && mr2 == mB) m_ph = P_DONE;
      else if (!e) begin
        if (midle == TIMEOUT - 1) m_ph = P_TO;
        else midle++;
      end
      if (e) midle = 0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_ph = P_IDLE; mB = 0; mf1 = 0; mf2 = 0; mr1 = 0; mr2 = 0; midle = 0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    chk("enable_1", bus.enable_1_o, m_en(mf1, mf2));
    chk("enable_2", bus.enable_2_o, m_en(mf2, mf1));
    chk("busy", bus.busy_o, (m_ph == P_RUN) || (m_ph == P_DRAIN));
    chk("finished", bus.finished_o, m_ph == P_DONE);
    chk("timeout", bus.timeout_o, m_ph == P_TO);
    chk("fetch_cnt_1", bus.fetch_cnt_1_o, mf1);
    chk("fetch_cnt_2", bus.fetch_cnt_2_o, mf2);
  end

  task automatic step(input logic st, input int b, input logic f1, input logic f2,
                      input logic r1, input logic r2);
    bus.start_i    = st;
    bus.budget_i   = CNT_W'(b);
    bus.fetch_1_i  = f1;
    bus.fetch_2_i  = f2;
    bus.retire_1_i = r1;
    bus.retire_2_i = r2;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: run did not complete");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [2:0] h1, h2;
    logic a1, a2, r1, r2, st;
    bit   saw_drain, quiet;
    int   nret, len;

    bus.start_i = 0; bus.budget_i = '0;
    bus.fetch_1_i = 0; bus.fetch_2_i = 0; bus.retire_1_i = 0; bus.retire_2_i = 0;
    idle(2);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_en1", bus.enable_1_o, 0);
    chk("rst_cnt1", bus.fetch_cnt_1_o, 0);
    rst_n = 1'b1;
    idle(2);

    // Lockstep, retire three cycles after fetch
    step(1, 4, 0, 0, 0, 0);
    h1 = '0; h2 = '0; saw_drain = 0; nret = 0;
    for (int n = 0; n < 40 && !bus.finished_o; n++) begin
      a1 = bus.enable_1_o; a2 = bus.enable_2_o;
      r1 = h1[2]; r2 = h2[2];
      nret += int'(r1) + int'(r2);
      h1 = {h1[1:0], a1}; h2 = {h2[1:0], a2};
      step(0, 0, a1, a2, r1, r2);
      if (bus.busy_o && bus.fetch_cnt_1_o == 4 && bus.fetch_cnt_2_o == 4) saw_drain = 1;
    end
    chk("lock_finished", bus.finished_o, 1);
    chk("lock_busy_low", bus.busy_o, 0);
    chk("lock_cnt1", bus.fetch_cnt_1_o, 4);
    chk("lock_cnt2", bus.fetch_cnt_2_o, 4);
    chk("lock_retires", nret, 8);
    chk("lock_drain_seen", saw_drain, 1);

    // Skew limit
    step(1, 10, 0, 0, 0, 0);
    for (int n = 0; n < 6; n++) step(0, 0, 1, 0, 0, 0);
    chk("skew_cnt1", bus.fetch_cnt_1_o, 2);
    chk("skew_en1_low", bus.enable_1_o, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("skew_en1_back", bus.enable_1_o, 1);
    idle(20);
    chk("skew_timeout", bus.timeout_o, 1);

    // Watchdog expiry after 16 idle cycles, then restart
    step(1, 5, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    idle(15);
    chk("to_not_yet", bus.timeout_o, 0);
    idle(1);
    chk("to_fired", bus.timeout_o, 1);
    chk("to_en1", bus.enable_1_o, 0);
    chk("to_cnt1", bus.fetch_cnt_1_o, 2);
    step(1, 1, 0, 0, 0, 0);
    chk("restart_cnt1", bus.fetch_cnt_1_o, 0);
    chk("restart_to_clr", bus.timeout_o, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    chk("restart_finish", bus.finished_o, 1);

    // Zero budget
    step(1, 0, 0, 0, 0, 0);
    chk("zero_finished", bus.finished_o, 1);
    chk("zero_en1", bus.enable_1_o, 0);
    for (int n = 0; n < 3; n++) step(0, 0, 1, 1, 0, 0);
    chk("zero_en2", bus.enable_2_o, 0);
    chk("zero_cnt2", bus.fetch_cnt_2_o, 0);

    // Ignored fetch, ignored start, retire saturation
    step(1, 5, 0, 0, 0, 0);
    for (int n = 0; n < 3; n++) step(0, 0, 1, 0, 0, 0);
    chk("ign_fetch_cnt1", bus.fetch_cnt_1_o, 2);
    step(1, 3, 0, 0, 0, 0);
    for (int n = 0; n < 20; n++) step(0, 0, bus.enable_1_o, bus.enable_2_o, 0, 0);
    chk("ign_start_cnt1", bus.fetch_cnt_1_o, 5);
    chk("ign_start_cnt2", bus.fetch_cnt_2_o, 5);
    chk("ign_drain_busy", bus.busy_o, 1);
    for (int n = 0; n < 6; n++) step(0, 0, 0, 0, 1, 0);
    for (int n = 0; n < 4; n++) step(0, 0, 0, 0, 0, 1);
    chk("sat_not_done", bus.finished_o, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("sat_done", bus.finished_o, 1);

    // Async reset in DRAIN
    step(1, 2, 0, 0, 0, 0);
    for (int n = 0; n < 4; n++) step(0, 0, bus.enable_1_o, bus.enable_2_o, 0, 0);
    chk("rd_busy", bus.busy_o, 1);
    bus.fetch_1_i = 0; bus.fetch_2_i = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rd_busy_drop", bus.busy_o, 0);
    chk("rd_cnt_drop", bus.fetch_cnt_1_o, 0);
    chk("rd_en_drop", bus.enable_2_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    chk("rd_idle_busy", bus.busy_o, 0);
    chk("rd_idle_fin", bus.finished_o, 0);

    // Random traffic
    for (int seg = 0; seg < 40; seg++) begin
      len = $urandom_range(10, 60);
      quiet = ($urandom_range(0, 4) == 0);
      for (int c = 0; c < len; c++) begin
        st = (!bus.busy_o && $urandom_range(0, 2) == 0) || ($urandom_range(0, 50) == 0);
        step(st, $urandom_range(0, 12),
             quiet ? 1'b0 : ($urandom_range(0, 9) < 6),
             quiet ? 1'b0 : ($urandom_range(0, 9) < 6),
             quiet ? 1'b0 : ($urandom_range(0, 9) < 4),
             quiet ? 1'b0 : ($urandom_range(0, 9) < 4));
      end
    end

    idle(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
